lsu_data_port: RTL



---
 rtl/lsu_data_port_pkg.sv | 20 ++
 rtl/lsu_data_port.sv | 109 ++++++++++
 2 files changed

// File: rtl/lsu_data_port_pkg.sv
// Shared types and constants for the load/store unit data-memory front end.
package lsu_data_port_pkg;

  localparam int unsigned LSU_DATA_WIDTH = 16;
  localparam int unsigned LSU_ADDR_WIDTH = 8;
  localparam int unsigned LSU_LANES      = 8;

  localparam logic LSU_OP_LOAD  = 1'b0;
  localparam logic LSU_OP_STORE = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StRequest,
    StWait,
    StDone
  } lsu_state_t;

  typedef logic [LSU_LANES-1:0][LSU_DATA_WIDTH-1:0] lsu_lane_data_t;

endpackage

// File: rtl/lsu_data_port.sv
// Load/store front end: latches one request, drives the 8-lane data-memory port,
// captures load data after MEM_LATENCY cycles and pulses lsu_done once.
module lsu_data_port
  import lsu_data_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned LANES       = 8,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             lsu_start,
  input  logic                             lsu_op,
  input  logic [ADDR_WIDTH-1:0]            lsu_base_addr,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] lsu_store_data,
  output logic                             lsu_busy,
  output logic                             lsu_done,
  output logic [LANES-1:0][DATA_WIDTH-1:0] lsu_load_data,
  output logic [LANES-1:0][ADDR_WIDTH-1:0] mem_addr,
  output logic [LANES-1:0][DATA_WIDTH-1:0] mem_write_data,
  output logic                             mem_write_en,
  output logic                             mem_read_en,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] mem_read_data
);

  localparam int unsigned CntW    = $clog2(MEM_LATENCY) + 1;
  localparam int unsigned CntInit = (MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0;

  lsu_state_t                       state_q, state_d;
  logic [CntW-1:0]                  cnt_q, cnt_d;
  logic                             op_q;
  logic [ADDR_WIDTH-1:0]            addr_q;
  logic [LANES-1:0][DATA_WIDTH-1:0] wdata_q;
  logic [LANES-1:0][DATA_WIDTH-1:0] load_data_q;
  logic                             capture;
  logic                             accept;

  assign accept = (state_q == StIdle) && lsu_start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (lsu_start) state_d = StRequest;
      end
      StRequest: begin
        if (op_q == LSU_OP_STORE) begin
          state_d = StDone;
        end else if (MEM_LATENCY == 1) begin
          capture = 1'b1;
          state_d = StDone;
        end else begin
          // Request cycle already counts as one cycle of read enable.
          cnt_d   = CntW'(CntInit);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= LSU_OP_LOAD;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q    <= lsu_op;
        addr_q  <= lsu_base_addr;
        wdata_q <= lsu_store_data;
      end
      if (capture) load_data_q <= mem_read_data;
    end
  end

  always_comb begin
    lsu_busy       = (state_q != StIdle);
    lsu_done       = (state_q == StDone);
    lsu_load_data  = load_data_q;
    // Lane offsets are applied by the data memory; every lane sees the base.
    mem_addr       = {LANES{addr_q}};
    mem_write_data = wdata_q;
    mem_write_en   = (state_q == StRequest) && (op_q == LSU_OP_STORE);
    mem_read_en    = ((state_q == StRequest) && (op_q == LSU_OP_LOAD)) || (state_q == StWait);
  end

endmodule
